logic_gate_unit: RTL and testbench
==================================

// Module: logic_gate_unit
// PURPOSE
//  Registered, parametrised successor of the basic two-input gate set.
//  Takes two WIDTH-bit operands plus a 3-bit op code, computes one bitwise gate function,
//    and returns the result through a 1-deep output register.
//  Input and output use valid/ready handshakes; a wrapping counter tracks completed results.
//  Sits between operand producers and downstream datapath logic in gate-level exercises.
// PARAMETERS
//  WIDTH  8   operand/result width in bits (>=1)
//  CNT_W  8   width of completed-result counter (>=1)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operand beat valid
//  in_ready   out  1        unit can accept operand beat
//  in_a       in   WIDTH    operand A
//  in_b       in   WIDTH    operand B
//  in_op      in   3        op code, gate_pkg::gate_op_e
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_y      out  WIDTH    result
//  out_op     out  3        op code that produced out_y
//  out_red    out  3        {xor-reduce, or-reduce, and-reduce} of out_y (REDUCE_EN only)
//  done_cnt   out  CNT_W    count of output transfers (out_valid & out_ready)
// BEHAVIOUR
//  - Op codes:
//      0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A (B ignored), 7 BUF A (B ignored).
//  - All 8 codes are legal; there is no error path.
//  - Reset: synchronous on the rst clock edge; takes priority over any handshake in that cycle.
//      out_valid=0, out_y=0, out_op=0, out_red=0, done_cnt=0.
//  - Transfer rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - in_ready = ~out_valid | out_ready (combinational; no bubble under continuous flow).
//  - Latency: 1 cycle. in_fire at edge N gives out_valid=1 with the result after edge N.
//  - Throughput: 1 result/cycle while out_ready stays high.
//  - Stall: out_valid & ~out_ready holds out_y/out_op/out_red stable; in_ready=0.
//  - Simultaneous in_fire & out_fire: register loads the new result; out_valid stays 1.
//  - out_fire without in_fire: out_valid clears to 0 next cycle; out_y keeps its last value.
//  - in_valid while in_ready=0: beat is not consumed; the source must hold it (AXI-style).
//  - done_cnt increments by 1 on each out_fire.
//  - done_cnt wraps from 2^CNT_W-1 to 0 with no flag.
//  - rst asserted mid-stall: the pending result is dropped and done_cnt is not incremented.
//  - No internal state other than the output register and counter; no X is propagated after reset.
// CONFIGURATION
//  - Macro LOGIC_GATE_UNIT_REDUCE_EN.
//  - Defined: out_red is computed from the next result and registered in the same edge
//      as out_y, so its latency and stall behaviour are identical to out_y.
//  - Undefined: out_red is tied to 3'b000 and no reduction logic is built.
//  - The port list does not change with the macro.
// STRUCTURE
//  - gate_pkg:
//      typedef enum logic [2:0] gate_op_e {OP_AND..OP_BUF}.
//      Constant GATE_OP_W = 3.
//  - Sub-module gate_core:
//      Purely combinational (a, b, op) -> y.
//      WIDTH-parametrised; one case on gate_op_e.
//  - Top level holds the handshake, output register, reduction logic and counter.
// TESTING
//  1. Reset check:
//       rst=1 for 2 cycles, then 0.
//       -> out_valid=0, out_y=0, done_cnt=0, in_ready=1.
//  2. Single beats, out_ready=1, a=8'hF0, b=8'hCC, ops 0..7 on consecutive cycles.
//       -> next-cycle out_y = C0, FC, 3F, 03, 3C, C3, 0F, F0.
//       -> done_cnt=8 after the last beat.
//  3. Backpressure:
//       out_ready=0 for 3 cycles after one beat (a=8'hAA, b=8'h55, op=4).
//       -> out_y=FF held; in_ready=0.
//       -> Release: one out_fire; done_cnt increments exactly once.
//  4. Simultaneous fire:
//       continuous in_valid with out_ready=1.
//       -> in_ready stays 1; one result per cycle; no drops or duplicates.
//  5. Wrap and reset mid-stall:
//       CNT_W=2, 5 transfers -> done_cnt=1.
//       Then stall a beat and pulse rst.
//       -> out_valid=0, done_cnt=0.
//  6. With LOGIC_GATE_UNIT_REDUCE_EN:
//       out_y=8'hFF -> out_red=3'b011.
//       out_y=8'h01 -> out_red=3'b110.
//     Without the macro: out_red=0 always.

Source files
------------

// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - op codes and shared constants for the logic gate unit
package gate_pkg;

  localparam int GATE_OP_W = 3;

  typedef enum logic [GATE_OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } gate_op_e;

endpackage

// File: rtl/gate_core.sv
// rtl/gate_core.sv - combinational bitwise gate selected by op code
module gate_core
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  gate_op_e         op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      OP_BUF:  y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_gate_unit.sv
// rtl/logic_gate_unit.sv - registered gate unit with valid/ready handshake; reduction output under LOGIC_GATE_UNIT_REDUCE_EN
module logic_gate_unit
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [GATE_OP_W-1:0] in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_y,
  output logic [GATE_OP_W-1:0] out_op,
  output logic [2:0]           out_red,
  output logic [CNT_W-1:0]     done_cnt
);

  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] y_next;

  // Ready looks straight through the output register so a draining result
  // never costs a bubble.
  assign in_ready = ~out_valid | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  gate_core #(.WIDTH(WIDTH)) u_core (
    .a  (in_a),
    .b  (in_b),
    .op (gate_op_e'(in_op)),
    .y  (y_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_op    <= '0;
      done_cnt  <= '0;
    end else begin
      if (in_fire) begin
        out_valid <= 1'b1;
        out_y     <= y_next;
        out_op    <= in_op;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      if (out_fire) begin
        done_cnt <= done_cnt + CNT_W'(1);
      end
    end
  end

`ifdef LOGIC_GATE_UNIT_REDUCE_EN
  // Bit order {xor, or, and}; loaded on the same edge as out_y so stalls hold both.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_red <= 3'b000;
    end else if (in_fire) begin
      out_red <= {^y_next, |y_next, &y_next};
    end
  end
`else
  assign out_red = 3'b000;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// tb/tb_logic_gate_unit.sv - directed self-checking bench for logic_gate_unit
module tb_logic_gate_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b, out_y;
  logic [2:0] in_op, out_op, out_red;
  logic [7:0] done_cnt;

  logic       rst_2;
  logic       in_valid_2, in_ready_2, out_valid_2, out_ready_2;
  logic [7:0] in_a_2, in_b_2, out_y_2;
  logic [2:0] in_op_2, out_op_2, out_red_2;
  logic [1:0] done_cnt_2;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_y [8];
  logic [7:0] exp_c [8];
  logic [2:0] red_ff, red_01;

  always #5 clk = ~clk;

  logic_gate_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_op(out_op), .out_red(out_red),
    .done_cnt(done_cnt)
  );

  logic_gate_unit #(.WIDTH(8), .CNT_W(2)) dut_2 (
    .clk(clk), .rst(rst_2),
    .in_valid(in_valid_2), .in_ready(in_ready_2),
    .in_a(in_a_2), .in_b(in_b_2), .in_op(in_op_2),
    .out_valid(out_valid_2), .out_ready(out_ready_2),
    .out_y(out_y_2), .out_op(out_op_2), .out_red(out_red_2),
    .done_cnt(done_cnt_2)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_y = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    exp_c = '{8'h0C, 8'h3F, 8'hF3, 8'hC0, 8'h33, 8'hCC, 8'hF0, 8'h0F};
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    red_ff = 3'b011;
    red_01 = 3'b110;
`else
    red_ff = 3'b000;
    red_01 = 3'b000;
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
    rst_2 = 1'b1; in_valid_2 = 1'b0; out_ready_2 = 1'b0;
    in_a_2 = '0; in_b_2 = '0; in_op_2 = '0;

    // Reset
    tick(); tick();
    rst = 1'b0; rst_2 = 1'b0;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_y", out_y, 0);
    check_eq("rst_out_op", out_op, 0);
    check_eq("rst_out_red", out_red, 0);
    check_eq("rst_done_cnt", done_cnt, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // All ops, one per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = 8'hF0; in_b = 8'hCC; in_op = 3'(i);
      tick();
      check_eq($sformatf("op%0d_y", i), out_y, exp_y[i]);
      check_eq($sformatf("op%0d_op", i), out_op, i);
      check_eq($sformatf("op%0d_valid", i), out_valid, 1);
    end
    in_valid = 1'b0;
    tick();
    check_eq("ops_done_cnt", done_cnt, 8);
    check_eq("ops_drained_valid", out_valid, 0);
    check_eq("ops_y_kept", out_y, 8'hF0);

    // Backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55; in_op = 3'd4;
    tick();
    in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 3'd0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("stall%0d_y", i), out_y, 8'hFF);
      check_eq($sformatf("stall%0d_valid", i), out_valid, 1);
      check_eq($sformatf("stall%0d_in_ready", i), in_ready, 0);
      check_eq($sformatf("stall%0d_cnt", i), done_cnt, 8);
      tick();
    end
    // Held beat while stalled must not be consumed
    in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h0F; in_op = 3'd0;
    tick();
    check_eq("stall_hold_y", out_y, 8'hFF);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("release_in_ready", in_ready, 1);
    tick();
    check_eq("release_cnt", done_cnt, 9);
    check_eq("release_valid", out_valid, 0);
    tick();
    check_eq("release_cnt_once", done_cnt, 9);

    // Continuous flow
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h3C; in_op = 3'(i);
      #1;
      check_eq($sformatf("flow%0d_in_ready", i), in_ready, 1);
      tick();
      check_eq($sformatf("flow%0d_y", i), out_y, exp_c[i]);
      check_eq($sformatf("flow%0d_valid", i), out_valid, 1);
      check_eq($sformatf("flow%0d_cnt", i), done_cnt, 9 + i);
    end
    in_valid = 1'b0;
    tick();
    check_eq("flow_final_cnt", done_cnt, 17);

    // Reduction outputs
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_op = 3'd0;
    tick();
    check_eq("red_ff_y", out_y, 8'hFF);
    check_eq("red_ff", out_red, red_ff);
    in_a = 8'h01; in_op = 3'd7;
    tick();
    check_eq("red_01_y", out_y, 8'h01);
    check_eq("red_01", out_red, red_01);
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick(); tick();
    check_eq("red_01_held", out_red, red_01);

    // Counter wrap on the 2-bit instance, then reset during a stall
    out_ready_2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid_2 = 1'b1; in_a_2 = 8'(i); in_b_2 = 8'hFF; in_op_2 = 3'd0;
      tick();
      check_eq($sformatf("wrap%0d_y", i), out_y_2, i);
    end
    in_valid_2 = 1'b0;
    tick();
    check_eq("wrap_cnt", done_cnt_2, 1);
    out_ready_2 = 1'b0;
    in_valid_2 = 1'b1; in_a_2 = 8'h5A; in_op_2 = 3'd7;
    tick();
    in_valid_2 = 1'b0;
    check_eq("mid_stall_valid", out_valid_2, 1);
    check_eq("mid_stall_in_ready", in_ready_2, 0);
    // Reset wins even with out_ready high on the same edge
    rst_2 = 1'b1; out_ready_2 = 1'b1;
    tick();
    rst_2 = 1'b0;
    check_eq("rst_stall_valid", out_valid_2, 0);
    check_eq("rst_stall_cnt", done_cnt_2, 0);
    check_eq("rst_stall_y", out_y_2, 0);
    tick();
    check_eq("rst_stall_cnt_after", done_cnt_2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
